// File: rtl/mem_word_adapter.sv
// mem_word_adapter
//   Bridges a 32-bit word request/response port onto a 16-bit (two byte lane)
//   memory. Each word access becomes up to two halfword accesses: the upper
//   halfword at the word address A, then the lower halfword at A+2. Data is
//   big-endian, so the byte at A sits in bits 31:24 of the word.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   word request handshake (ready only in IDLE)
//   req_we                1 = write, 0 = read
//   req_addr              byte address, bits [1:0] ignored
//   req_be                byte enables, be[3] = byte A ... be[0] = byte A+3
//   req_wdata             write data
//   rsp_valid/rsp_ready   read response handshake
//   rsp_rdata             read data, held until the next read capture
//   mem_en, mem_rd_en     memory enable / read enable
//   mem_wr_en             per-byte write enables, index 0 = even byte
//   mem_addr              halfword-aligned byte address (holds when idle)
//   mem_din               memory write data (holds when idle)
//   mem_dout              registered memory read data (one cycle latency)

module mem_word_adapter #(
    parameter int  MEM_DEPTH  = 4096,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_be,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_rd_en,
    output logic [0:1]            mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [0:1][7:0]       mem_din,
    input  logic [0:1][7:0]       mem_dout
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] HALF_OFS  = ADDR_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RSP  = 3'd4,
        WR0  = 3'd5,
        WR1  = 3'd6
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   base;
    logic [31:0]             wdata_cur;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [0:1][7:0]         mem_din_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        base       = addr_q;
        wdata_cur  = wdata_q;
        mem_addr_d = mem_addr;
        mem_din_d  = mem_din;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_en     = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 2'b00;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // The registered request is not visible yet on the
                    // acceptance edge, so the first access is set up from
                    // the live request inputs.
                    accept    = 1'b1;
                    base      = req_addr & WORD_MASK;
                    wdata_cur = req_wdata;
                    if (!req_we)                state_d = RD0;
                    else if (|req_be[3:2])      state_d = WR0;
                    else if (|req_be[1:0])      state_d = WR1;
                    else                        state_d = IDLE;
                end
            end
            RD0: begin
                mem_en    = 1'b1;
                mem_rd_en = 1'b1;
                state_d   = RD1;
            end
            RD1: begin
                mem_en    = 1'b1;
                mem_rd_en = 1'b1;
                state_d   = RD2;
            end
            RD2: state_d = RSP;
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            WR0: begin
                mem_en    = 1'b1;
                mem_wr_en = be_q[3:2];
                state_d   = (|be_q[1:0]) ? WR1 : IDLE;
            end
            WR1: begin
                mem_en    = 1'b1;
                mem_wr_en = be_q[1:0];
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Address/data registers are loaded on the edge entering an access
        // state, so they line up with mem_en; otherwise they hold.
        case (state_d)
            RD0: mem_addr_d = base;
            RD1: mem_addr_d = base | HALF_OFS;
            WR0: begin
                mem_addr_d = base;
                mem_din_d  = wdata_cur[31:16];
            end
            WR1: begin
                mem_addr_d = base | HALF_OFS;
                mem_din_d  = wdata_cur[15:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q  <= base;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
            mem_addr <= mem_addr_d;
            mem_din  <= mem_din_d;
            // mem_dout lags the issue by one cycle: the upper halfword
            // issued in RD0 arrives during RD1, the lower one during RD2.
            if (state == RD1) rsp_rdata[31:16] <= mem_dout;
            if (state == RD2) rsp_rdata[15:0]  <= mem_dout;
        end
    end

endmodule

// File: doc/mem_word_adapter.md
MEM_WORD_ADAPTER -- requirements
Module: mem_word_adapter

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4096: depth of the attached halfword memory, in 16-bit halfwords.
REQ-002 SHALL have local parameter ADDR_WIDTH = $clog2(MEM_DEPTH*2): byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous reset, active low.
REQ-006 req_valid  in  1  word request present.
REQ-007 req_ready  out  1  adapter can accept a request.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored, treated as 0.
REQ-010 req_be  in  4  byte enables; be[3] = bits 31:24 = byte A, be[0] = bits 7:0 = byte A+3.
REQ-011 req_wdata  in  32  write data, big-endian.
REQ-012 rsp_valid  out  1  read data available.
REQ-013 rsp_ready  in  1  consumer accepts read data.
REQ-014 rsp_rdata  out  32  read data, big-endian.
REQ-015 mem_en, mem_rd_en  out  1 each  memory enable and read enable.
REQ-016 mem_wr_en  out  [0:1]  byte write enables; index 0 = even byte = bits 15:8.
REQ-017 mem_addr  out  ADDR_WIDTH  halfword-aligned byte address; bit 0 always 0.
REQ-018 mem_din  out  [0:1][7:0]  memory write data.
REQ-019 mem_dout  in  [0:1][7:0]  memory read data; registered, valid the cycle after a read issue.

Function
REQ-020 FSM states SHALL be: IDLE, RD0, RD1, RD2, RSP, WR0, WR1.
REQ-021 Handshake rules:
- req_ready = 1 only in IDLE.
- A request is accepted on a clock edge where req_valid and req_ready are both 1.
- req_addr, req_be and req_wdata SHALL be registered on acceptance.
REQ-022 Read path: IDLE -> RD0 -> RD1 -> RD2 -> RSP.
- RD0: issue upper halfword at A (mem_en=1, mem_rd_en=1, mem_wr_en=00).
- RD1: issue lower halfword at A+2; capture mem_dout into rdata[31:16] at end of cycle.
- RD2: no memory access; capture mem_dout into rdata[15:0] at end of cycle.
REQ-023 RSP: rsp_valid=1 with rsp_rdata held stable; on rsp_valid && rsp_ready -> IDLE.
- rsp_rdata SHALL keep its value after the handshake until the next read capture.
REQ-024 Read latency: request accepted at edge E0 -> rsp_valid=1 after edge E3; minimum 5-cycle initiation interval.
REQ-025 Write path:
- WR0: A, mem_wr_en={be[3],be[2]}, mem_din=wdata[31:16].
- WR1: A+2, mem_wr_en={be[1],be[0]}, mem_din=wdata[15:0].
- mem_en=1 and mem_rd_en=0 in both states; no response is generated.
REQ-026 Write half skipping:
- be[3:2]==00: skip WR0 (IDLE -> WR1).
- be[1:0]==00: WR0 -> IDLE, no WR1.
- be==0000: request accepted, no memory access, stay IDLE.
REQ-027 Outside RD0, RD1, WR0 and WR1: mem_en=0, mem_rd_en=0, mem_wr_en=00.
- mem_addr and mem_din hold their last values.
REQ-028 The adapter SHALL never assert mem_rd_en and any mem_wr_en bit in the same cycle.
REQ-029 Word-aligned A SHALL guarantee that A+2 never crosses a word boundary.
- The top word (A = 2*MEM_DEPTH-4) SHALL need no wrap handling.
REQ-030 req_valid changes outside IDLE SHALL have no effect.
REQ-031 rsp_ready while not in RSP SHALL be ignored.

Reset
REQ-032 On rst_n=0, asynchronously and immediately:
- FSM -> IDLE.
- rsp_valid, mem_en, mem_rd_en = 0; mem_wr_en = 00.
- mem_addr, mem_din, rsp_rdata and all captured request registers = 0.
- req_ready = 1 once the FSM is in IDLE.
REQ-033 Reset mid-operation SHALL abort the transaction silently; no partial response is produced.
- Any halfword already written stays written.
REQ-034 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 Write/read round trip:
- Stimulus: write A=0x010, be=1111, wdata=0xDEADBEEF; then read A=0x010, rsp_ready=1.
- Response: rsp_rdata=0xDEADBEEF, rsp_valid 3 edges after acceptance; mem halfword 0x010 = 0xDEAD, 0x012 = 0xBEEF.
REQ-036 Partial byte enables:
- Stimulus: preload 0x11223344 at A=0x020; write be=0110, wdata=0xAABBCCDD; read back.
- Response: 0x11BBCC44.
- Only WR0 (wr_en 01) and WR1 (wr_en 10) are issued.
REQ-037 Skipped halves:
- write be=0011: exactly one memory cycle, at mem_addr A+2.
- write be=0000: zero memory cycles; req_ready back to 1 the next cycle.
REQ-038 Response backpressure:
- Stimulus: read with rsp_ready=0 for 4 cycles.
- Response: rsp_valid stays 1, rsp_rdata stable, req_ready stays 0; IDLE one edge after rsp_ready=1.
REQ-039 Reset mid-read:
- Stimulus: assert rst_n=0 during RD1.
- Response: all outputs reset immediately; no rsp_valid afterward.
- A new read after release returns the correct data.
REQ-040 Boundary and alignment:
- Read of the top word, A = 2*MEM_DEPTH-4, returns the correct data.
- A=0x013 accesses word 0x010.
